// File: rtl/hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_ctrl_pkg;

   localparam int REG_ADDR_W_DEF  = 3;
   localparam int STALL_CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      RUN         = 2'd0,
      MEM_WAIT    = 2'd1,
      BRANCH_PEND = 2'd2
   } hazard_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-observation and stall/flush bundle between the core pipeline and hazard_ctrl.
interface hazard_ctrl_if
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
   parameter int STALL_CNT_W = STALL_CNT_W_DEF
);

   logic                   id_valid;
   logic [REG_ADDR_W-1:0]  id_rs1;
   logic [REG_ADDR_W-1:0]  id_rs2;
   logic                   id_use_rs1;
   logic                   id_use_rs2;
   logic [REG_ADDR_W-1:0]  id_rd;
   logic                   id_write_en;
   logic [REG_ADDR_W-1:0]  ex_rd;
   logic                   ex_write_en;
   logic                   ex_mem_read;
   logic                   ex_branch_taken;
   logic                   mem_req;
   logic                   mem_ready;
   logic [REG_ADDR_W-1:0]  wb_rd;
   logic                   wb_write_en;

   logic                   pc_stall;
   logic                   ifid_stall;
   logic                   idex_stall;
   logic                   exmem_stall;
   logic                   ifid_flush;
   logic                   idex_flush;
   logic [1:0]             hazard_state;
   logic [STALL_CNT_W-1:0] stall_count;

   // master: the hazard controller; slave: the pipeline that consumes its controls
   modport master (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_write_en,
      input  ex_rd, ex_write_en, ex_mem_read, ex_branch_taken,
      input  mem_req, mem_ready, wb_rd, wb_write_en,
      output pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush,
      output hazard_state, stall_count
   );

   modport slave (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_write_en,
      output ex_rd, ex_write_en, ex_mem_read, ex_branch_taken,
      output mem_req, mem_ready, wb_rd, wb_write_en,
      input  pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush,
      input  hazard_state, stall_count
   );

endinterface

// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard and RAW detect for a pipeline without forwarding.
module hazard_scoreboard
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_hold,
   input  logic                  i_issue_wr,
   input  logic [REG_ADDR_W-1:0] i_rd,
   input  logic                  i_wb_we,
   input  logic [REG_ADDR_W-1:0] i_wb_rd,
   input  logic                  i_id_valid,
   input  logic [REG_ADDR_W-1:0] i_rs1,
   input  logic [REG_ADDR_W-1:0] i_rs2,
   input  logic                  i_use_rs1,
   input  logic                  i_use_rs2,
   output logic                  o_raw
);

   localparam int NREG = 1 << REG_ADDR_W;

   logic [NREG-1:0] r_pend;
   logic [NREG-1:0] w_set;
   logic [NREG-1:0] w_clr;
   logic            w_busy1;
   logic            w_busy2;

   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (i_issue_wr) w_set[i_rd]    = 1'b1;
      if (i_wb_we)    w_clr[i_wb_rd] = 1'b1;
   end

   // set is applied after clear so a same-cycle issue of the retiring register stays pending
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pend <= '0;
      end else if (!i_hold) begin
         r_pend <= (r_pend & ~w_clr) | w_set;
      end
   end

   // the write-back happening this cycle satisfies the read through the RF bypass
   assign w_busy1 = r_pend[i_rs1] && !(i_wb_we && (i_wb_rd == i_rs1));
   assign w_busy2 = r_pend[i_rs2] && !(i_wb_we && (i_wb_rd == i_rs2));
   assign o_raw   = i_id_valid && ((i_use_rs1 && w_busy1) || (i_use_rs2 && w_busy2));

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use/RAW bubbles, branch squash, memory freeze.
// Define HAZARD_FORWARD_EN when the datapath forwards; only load-use then stalls and no scoreboard is built.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
   parameter int STALL_CNT_W = STALL_CNT_W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   hazard_ctrl_if.master bus
);

   hazard_state_t          r_state;
   logic                   r_branch_pend;
   logic [STALL_CNT_W-1:0] r_stall_count;

   logic w_mem_busy;
   logic w_load_use;
   logic w_raw;
   logic w_issue;
   logic w_pc_stall, w_ifid_stall, w_idex_stall, w_exmem_stall;
   logic w_ifid_flush, w_idex_flush;

   function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
      return (&v) ? v : v + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
   endfunction

   assign w_mem_busy = bus.mem_req && !bus.mem_ready;
   assign w_load_use = bus.id_valid && bus.ex_mem_read && bus.ex_write_en &&
                       ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                        (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

   // outputs are forced low while reset is held, independent of the clock
   always_comb begin
      w_pc_stall    = 1'b0;
      w_ifid_stall  = 1'b0;
      w_idex_stall  = 1'b0;
      w_exmem_stall = 1'b0;
      w_ifid_flush  = 1'b0;
      w_idex_flush  = 1'b0;
      if (rst) begin
         unique case (r_state)
            RUN: begin
               if (!w_mem_busy) begin
                  if (bus.ex_branch_taken) begin
                     w_ifid_flush = 1'b1;
                     w_idex_flush = 1'b1;
                  end else if (w_load_use || w_raw) begin
                     w_pc_stall   = 1'b1;
                     w_ifid_stall = 1'b1;
                     w_idex_flush = 1'b1;
                  end
               end
            end
            MEM_WAIT: begin
               w_pc_stall    = 1'b1;
               w_ifid_stall  = 1'b1;
               w_idex_stall  = 1'b1;
               w_exmem_stall = 1'b1;
            end
            BRANCH_PEND: begin
               w_ifid_flush = 1'b1;
               w_idex_flush = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign w_issue = bus.id_valid &&
                    !(w_pc_stall || w_ifid_stall || w_idex_stall || w_exmem_stall ||
                      w_ifid_flush || w_idex_flush);

`ifdef HAZARD_FORWARD_EN
   logic w_unused;
   assign w_raw    = 1'b0;
   assign w_unused = ^{bus.id_rd, bus.id_write_en, bus.wb_rd, bus.wb_write_en, w_issue};
`else
   hazard_scoreboard #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .i_hold     (r_state == MEM_WAIT),
      .i_issue_wr (w_issue && bus.id_write_en),
      .i_rd       (bus.id_rd),
      .i_wb_we    (bus.wb_write_en),
      .i_wb_rd    (bus.wb_rd),
      .i_id_valid (bus.id_valid),
      .i_rs1      (bus.id_rs1),
      .i_rs2      (bus.id_rs2),
      .i_use_rs1  (bus.id_use_rs1),
      .i_use_rs2  (bus.id_use_rs2),
      .o_raw      (w_raw)
   );
`endif

   // a branch seen on the very cycle memory completes still owes its flush
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= RUN;
         r_branch_pend <= 1'b0;
         r_stall_count <= '0;
      end else begin
         if (w_pc_stall) r_stall_count <= sat_inc(r_stall_count);
         unique case (r_state)
            RUN: begin
               if (w_mem_busy) r_state <= MEM_WAIT;
            end
            MEM_WAIT: begin
               if (bus.ex_branch_taken) r_branch_pend <= 1'b1;
               if (bus.mem_ready)
                  r_state <= (r_branch_pend || bus.ex_branch_taken) ? BRANCH_PEND : RUN;
            end
            BRANCH_PEND: begin
               r_branch_pend <= 1'b0;
               r_state       <= RUN;
            end
            default: r_state <= RUN;
         endcase
      end
   end

   assign bus.pc_stall     = w_pc_stall;
   assign bus.ifid_stall   = w_ifid_stall;
   assign bus.idex_stall   = w_idex_stall;
   assign bus.exmem_stall  = w_exmem_stall;
   assign bus.ifid_flush   = w_ifid_flush;
   assign bus.idex_flush   = w_idex_flush;
   assign bus.hazard_state = r_state;
   assign bus.stall_count  = r_stall_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: behavioural model checked every cycle plus directed literal checks.
module tb_hazard_ctrl;

   localparam int AW      = 3;
   localparam int CW      = 4;
   localparam int CNT_MAX = (1 << CW) - 1;
   localparam int S_RUN   = 0;
   localparam int S_WAIT  = 1;
   localparam int S_BPEND = 2;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;

   hazard_ctrl_if #(.REG_ADDR_W(AW), .STALL_CNT_W(CW)) bus ();

   hazard_ctrl #(.REG_ADDR_W(AW), .STALL_CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   logic [5:0] dut_ctl;
   assign dut_ctl = {bus.pc_stall, bus.ifid_stall, bus.idex_stall, bus.exmem_stall,
                     bus.ifid_flush, bus.idex_flush};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_state;
   int m_count;
   bit m_owed;
   int m_pend[$];
   logic [5:0] m_c;

   function automatic bit in_list(input int r);
      foreach (m_pend[i]) if (m_pend[i] == r) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit still_pending(input int r);
      if (bus.wb_write_en && int'(bus.wb_rd) == r) return 1'b0;
      return in_list(r);
   endfunction

   function automatic bit model_load_use();
      return bus.id_valid && bus.ex_mem_read && bus.ex_write_en &&
             ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
              (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
   endfunction

   function automatic bit model_raw();
      if (!bus.id_valid) return 1'b0;
      return (bus.id_use_rs1 && still_pending(int'(bus.id_rs1))) ||
             (bus.id_use_rs2 && still_pending(int'(bus.id_rs2)));
   endfunction

   // {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush}
   function automatic logic [5:0] model_ctl();
      bit run_ok, freeze, squash, bubble;
      if (!rst) return 6'b0;
      run_ok = (m_state == S_RUN) && !(bus.mem_req && !bus.mem_ready);
      freeze = (m_state == S_WAIT);
      squash = (m_state == S_BPEND) || (run_ok && bus.ex_branch_taken);
      bubble = run_ok && !bus.ex_branch_taken && (model_load_use() || model_raw());
      return {freeze || bubble, freeze || bubble, freeze, freeze, squash, squash || bubble};
   endfunction

   task automatic model_reset();
      m_state = S_RUN;
      m_count = 0;
      m_owed  = 1'b0;
      m_pend.delete();
   endtask

   task automatic drop_pending(input int r);
      for (int i = 0; i < m_pend.size(); i++) begin
         if (m_pend[i] == r) begin
            m_pend.delete(i);
            break;
         end
      end
   endtask

   always @(negedge rst) model_reset();

   always @(posedge clk) begin
      if (!rst) begin
         model_reset();
      end else begin
         m_c = model_ctl();
         if (m_c[5] && m_count < CNT_MAX) m_count++;
         if (m_state != S_WAIT) begin
            if (bus.wb_write_en) drop_pending(int'(bus.wb_rd));
            if (bus.id_valid && bus.id_write_en && m_c == 6'b0 && !in_list(int'(bus.id_rd)))
               m_pend.push_back(int'(bus.id_rd));
         end
         case (m_state)
            S_RUN:   if (bus.mem_req && !bus.mem_ready) m_state = S_WAIT;
            S_WAIT: begin
               if (bus.ex_branch_taken) m_owed = 1'b1;
               if (bus.mem_ready) m_state = m_owed ? S_BPEND : S_RUN;
            end
            default: begin
               m_owed  = 1'b0;
               m_state = S_RUN;
            end
         endcase
      end
   end

   // per-cycle compare, well clear of the rising edge
   always @(negedge clk) begin
      #3;
      check("model_ctl", {26'b0, dut_ctl}, {26'b0, model_ctl()});
      check("model_state", {30'b0, bus.hazard_state}, m_state);
      check("model_count", {28'b0, bus.stall_count}, m_count);
   end

   // ---------------- directed stimulus ----------------
   task automatic idle();
      bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
      bus.id_rd = 0; bus.id_write_en = 0; bus.ex_rd = 0; bus.ex_write_en = 0; bus.ex_mem_read = 0;
      bus.ex_branch_taken = 0; bus.mem_req = 0; bus.mem_ready = 0; bus.wb_rd = 0; bus.wb_write_en = 0;
   endtask

   task automatic go();
      @(negedge clk);
      idle();
   endtask

   task automatic load_use(input logic [AW-1:0] rs1, input logic [AW-1:0] exrd);
      bus.id_valid = 1; bus.id_use_rs1 = 1; bus.id_rs1 = rs1;
      bus.ex_rd = exrd; bus.ex_mem_read = 1; bus.ex_write_en = 1;
   endtask

   task automatic lit(input string name, input logic [5:0] ctl, input int st);
      check({name, "_ctl"}, {26'b0, dut_ctl}, {26'b0, ctl});
      check({name, "_state"}, {30'b0, bus.hazard_state}, st);
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      model_reset();
      idle();
      rst = 1'b1;
      #1 rst = 1'b0;
      go(); #3;
      lit("reset", 6'b0, 0);
      check("reset_count", {28'b0, bus.stall_count}, 0);
      go(); rst = 1'b1;

      // load-use: one bubble
      go(); load_use(3, 3); #3 lit("lu", 6'b110001, 0);
      go(); bus.id_valid = 1; bus.id_use_rs1 = 1; bus.id_rs1 = 3; #3 lit("lu_after", 6'b0, 0);
      check("lu_count", {28'b0, bus.stall_count}, 1);

      // branch wins over load-use
      go(); load_use(3, 3); bus.ex_branch_taken = 1; #3 lit("br_lu", 6'b000011, 0);

      // memory wait, ready low for four cycles
      go(); bus.mem_req = 1; #3 lit("mw_enter", 6'b0, 0);
      for (int k = 0; k < 3; k++) begin
         go(); bus.mem_req = 1; #3 lit("mw_hold", 6'b111100, 1);
      end
      go(); bus.mem_req = 1; bus.mem_ready = 1; #3 lit("mw_ready", 6'b111100, 1);
      go(); #3 lit("mw_exit", 6'b0, 0);
      check("mw_count", {28'b0, bus.stall_count}, 5);

      // branch during wait owes one flush cycle
      go(); bus.mem_req = 1;
      go(); bus.mem_req = 1; bus.ex_branch_taken = 1; #3 lit("bw_branch", 6'b111100, 1);
      go(); bus.mem_req = 1;
      go(); bus.mem_req = 1; bus.mem_ready = 1;
      go(); #3 lit("bw_pend", 6'b000011, 2);
      go(); #3 lit("bw_done", 6'b0, 0);
      check("bw_count", {28'b0, bus.stall_count}, 8);

      // scoreboard: write r5 then read it until write-back
      go(); bus.id_valid = 1; bus.id_write_en = 1; bus.id_rd = 5; #3 lit("sb_issue", 6'b0, 0);
      for (int k = 0; k < 2; k++) begin
         go(); bus.id_valid = 1; bus.id_use_rs1 = 1; bus.id_rs1 = 5; #3 lit("sb_raw", 6'b110001, 0);
      end
      go(); bus.id_valid = 1; bus.id_use_rs1 = 1; bus.id_rs1 = 5;
      bus.wb_write_en = 1; bus.wb_rd = 5; #3 lit("sb_bypass", 6'b0, 0);
      go(); bus.id_valid = 1; bus.id_use_rs1 = 1; bus.id_rs1 = 5; #3 lit("sb_clear", 6'b0, 0);
      // same-cycle set and clear of r6 leaves it pending
      go(); bus.id_valid = 1; bus.id_write_en = 1; bus.id_rd = 6; bus.wb_write_en = 1; bus.wb_rd = 6;
      go(); bus.id_valid = 1; bus.id_use_rs2 = 1; bus.id_rs2 = 6; #3 lit("sb_setclr", 6'b110001, 0);
      go(); bus.id_valid = 1; bus.id_use_rs2 = 1; bus.id_rs2 = 6;
      bus.wb_write_en = 1; bus.wb_rd = 6; #3 lit("sb_wb6", 6'b0, 0);

      // register 0 is an ordinary index; unused sources never match
      go(); load_use(0, 0); #3 lit("r0_lu", 6'b110001, 0);
      go(); load_use(0, 0); bus.id_use_rs1 = 0; #3 lit("r0_unused", 6'b0, 0);
      check("sb_count", {28'b0, bus.stall_count}, 12);

      // counter saturation
      go(); bus.mem_req = 1;
      for (int k = 0; k < 4; k++) begin go(); bus.mem_req = 1; end
      go(); bus.mem_req = 1; bus.mem_ready = 1;
      go(); #3 check("sat_count", {28'b0, bus.stall_count}, CNT_MAX);
      go(); load_use(2, 2); #3 lit("sat_lu", 6'b110001, 0);
      go(); #3 check("sat_hold", {28'b0, bus.stall_count}, CNT_MAX);

      // asynchronous reset in MEM_WAIT drops the owed flush and the scoreboard
      go(); bus.id_valid = 1; bus.id_write_en = 1; bus.id_rd = 7;
      go(); bus.mem_req = 1;
      go(); bus.mem_req = 1; bus.ex_branch_taken = 1; #3 lit("rw_wait", 6'b111100, 1);
      go(); bus.mem_req = 1;
      #1 rst = 1'b0;
      #1 lit("rw_async", 6'b0, 0);
      check("rw_count", {28'b0, bus.stall_count}, 0);
      go(); rst = 1'b1; bus.mem_req = 1; bus.mem_ready = 1;
      bus.id_valid = 1; bus.id_use_rs1 = 1; bus.id_rs1 = 7; #3 lit("rw_release", 6'b0, 0);
      go(); #3 lit("rw_no_pend", 6'b0, 0);
      go();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage core. It observes the ID, EX, MEM and WB stages and drives the stall and flush inputs of the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It inserts bubbles for load-use and RAW hazards, squashes wrong-path instructions on taken branches, and freezes the pipeline while data memory is not ready. It is the control-side counterpart of the pipeline registers, which only consume these signals.

## Interface
Parameters:
- REG_ADDR_W, 3, register-file index width
- STALL_CNT_W, 16, width of the stall performance counter

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID stage holds a real instruction
- id_rs1, id_rs2  in  REG_ADDR_W  ID source registers
- id_use_rs1, id_use_rs2  in  1  corresponding source is actually read
- id_rd  in  REG_ADDR_W  ID destination register
- id_write_en  in  1  ID instruction writes the RF
- ex_rd  in  REG_ADDR_W  EX destination register
- ex_write_en  in  1  EX instruction writes the RF
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  branch resolved taken in EX
- mem_req  in  1  MEM stage is accessing data memory
- mem_ready  in  1  data memory completes this cycle
- wb_rd  in  REG_ADDR_W  WB destination register
- wb_write_en  in  1  WB writes the RF this cycle
- pc_stall, ifid_stall, idex_stall, exmem_stall  out  1  hold the register
- ifid_flush, idex_flush  out  1  load a bubble (all-zero) on the next edge
- hazard_state  out  2  current FSM state
- stall_count  out  STALL_CNT_W  saturating count of cycles with pc_stall=1

## Operation
- FSM states:
  - RUN=0: normal operation.
  - MEM_WAIT=1: data memory is busy; the pipeline is frozen.
  - BRANCH_PEND=2: a taken branch was seen during MEM_WAIT and its flush is owed.
- RUN:
  - If mem_req && !mem_ready, go to MEM_WAIT.
  - Else if ex_branch_taken, assert ifid_flush and idex_flush.
  - Else if a load-use or RAW hazard exists, assert pc_stall, ifid_stall and idex_flush.
- MEM_WAIT:
  - pc_stall, ifid_stall, idex_stall and exmem_stall are all 1. No flushes are asserted.
  - If ex_branch_taken is ever sampled here, set an internal branch_pend bit.
  - When mem_ready=1, go to BRANCH_PEND if branch_pend is set, else go to RUN.
- BRANCH_PEND: lasts one cycle. Assert ifid_flush and idex_flush, clear branch_pend, then go to RUN.
- Load-use hazard: id_valid && ex_mem_read && ex_write_en && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
- Priority: mem wait > branch flush > load-use/RAW stall. When a branch and a load-use hazard occur together, only the flush is applied.
- Register index 0 has no special meaning; all indices are compared.
- stall_count saturates at all-ones.

## Timing
- All stall/flush outputs are combinational from the current state and inputs. They act on the next rising edge of the pipeline registers.
- Load-use costs exactly one bubble.
- A taken branch costs two squashed instructions (IF/ID and ID/EX).
- A mem wait of N cycles with mem_ready low freezes the pipeline N cycles. The freeze ends on the cycle mem_ready=1.
- Reset values: hazard_state=RUN, stall_count=0, scoreboard cleared, branch_pend=0. All stall/flush outputs are 0 while rst=0.
- Reset asserted mid-MEM_WAIT or mid-BRANCH_PEND returns to RUN immediately, and the owed flush is dropped.

## Configuration
- HAZARD_FORWARD_EN defined: the datapath has EX/MEM/WB forwarding. Only load-use hazards stall, and no scoreboard is built.
- HAZARD_FORWARD_EN undefined: a 2^REG_ADDR_W-bit pending scoreboard is built.
  - A bit is set when an instruction with id_write_en issues from ID, i.e. id_valid=1, no stall and no flush.
  - A bit is cleared on wb_write_en for wb_rd.
  - Any used ID source with its pending bit set is a RAW hazard.
  - A WB clear of the same register in the same cycle bypasses the bit, so no stall is raised.
  - A set and a clear of the same register in the same cycle leave the bit set.
  - The scoreboard holds its value during MEM_WAIT.

## Structure
- The shared package (defines package) holds:
  - the hazard_state_t enum (RUN, MEM_WAIT, BRANCH_PEND)
  - the REG_ADDR_W default, equal to the register-field width
- Sub-module hazard_scoreboard contains the pending-bit array and the RAW compare. It is instantiated only when HAZARD_FORWARD_EN is undefined.

## Test plan
- Load-use: load with ex_rd=3, ID reading rs1=3 -> exactly one cycle of pc_stall=ifid_stall=idex_flush=1, then RUN; stall_count=1.
- Branch and load-use together: ex_branch_taken=1 and load-use in the same cycle -> ifid_flush=idex_flush=1 and pc_stall=0.
- Mem wait: mem_req=1 with mem_ready low for 4 cycles -> hazard_state=1 and all four stalls=1 for 4 cycles; RUN on the cycle mem_ready rises.
- Branch during wait: ex_branch_taken pulsed in MEM_WAIT -> on mem_ready, one BRANCH_PEND cycle with both flushes.
- No forwarding (HAZARD_FORWARD_EN undefined): issue a write to r5, then ID reads r5 -> stall until wb_write_en with wb_rd=5; the stall drops in that same cycle.
- Reset: drop rst during MEM_WAIT -> all outputs 0 asynchronously; state RUN after release.
